// File: rtl/crc_pkg.sv
// Shared CRC-14 definitions so the encoder and checker agree on the polynomial,
// the field layout and the checker state encoding.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } crc_chk_state_t;

  localparam int          CRC14_W    = 14;
  localparam logic [13:0] CRC14_POLY = 14'h0599;
  localparam int          MSG_W      = 8;
  localparam int          CODEWORD_W = MSG_W + CRC14_W;

endpackage

// File: rtl/crc_lfsr_step.sv
// One combinational Galois LFSR step: shifts a single message bit into a CRC.
module crc_lfsr_step #(
  parameter int               CRC_W = 14,
  parameter logic [CRC_W-1:0] POLY  = 14'h0599
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] next_crc_o
);

  logic fb;

  assign fb         = bit_i ^ crc_i[CRC_W-1];
  assign next_crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC-14 checker: recomputes the CRC one message bit per cycle,
// compares it to the received field and keeps a saturating failure count.
module crc_check
  import crc_pkg::*;
#(
  parameter int               DATA_W = MSG_W,
  parameter int               CRC_W  = CRC14_W,
  parameter logic [CRC_W-1:0] POLY   = CRC14_POLY,
  parameter int               CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W+CRC_W-1:0] data_in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       data_out,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic [CRC_W-1:0]        syndrome,
  output logic [CNT_W-1:0]        err_count
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  crc_chk_state_t state_q, state_d;
  logic [DATA_W+CRC_W-1:0] codeword_q, codeword_d;
  logic [CRC_W-1:0]        crc_acc_q, crc_acc_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic                    crc_ok_q, crc_ok_d;
  logic                    crc_err_q, crc_err_d;
  logic [CRC_W-1:0]        syndrome_q, syndrome_d;
  logic [CNT_W-1:0]        err_count_q, err_count_d;

  logic [DATA_W-1:0] msg_w;
  logic [CRC_W-1:0]  step_next;
  logic [CRC_W-1:0]  synd_w;

  assign msg_w  = codeword_q[DATA_W+CRC_W-1:CRC_W];
  assign synd_w = crc_acc_q ^ codeword_q[CRC_W-1:0];

  crc_lfsr_step #(
    .CRC_W(CRC_W),
    .POLY (POLY)
  ) u_step (
    .crc_i     (crc_acc_q),
    .bit_i     (msg_w[bit_cnt_q]),
    .next_crc_o(step_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      codeword_q  <= '0;
      crc_acc_q   <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      syndrome_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      codeword_q  <= codeword_d;
      crc_acc_q   <= crc_acc_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      data_out_q  <= data_out_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      syndrome_q  <= syndrome_d;
      err_count_q <= err_count_d;
    end
  end

  // Results are only rewritten in CHECK, so they hold between checks.
  always_comb begin
    state_d     = state_q;
    codeword_d  = codeword_q;
    crc_acc_d   = crc_acc_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    data_out_d  = data_out_q;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    syndrome_d  = syndrome_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          codeword_d = data_in;
          crc_acc_d  = '0;
          bit_cnt_d  = BCW'(DATA_W - 1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        crc_acc_d = step_next;
        bit_cnt_d = bit_cnt_q - BCW'(1);
        if (bit_cnt_q == '0) state_d = CHECK;
      end
      CHECK: begin
        syndrome_d = synd_w;
        data_out_d = msg_w;
        crc_ok_d   = (synd_w == '0);
        crc_err_d  = (synd_w != '0);
        done_d     = 1'b1;
        if ((synd_w != '0) && (err_count_q != {CNT_W{1'b1}}))
          err_count_d = err_count_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign syndrome  = syndrome_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check; a second instance with a 2-bit counter shares
// the stimulus to exercise error-count saturation.
module tb_crc_check;
  import crc_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [CODEWORD_W-1:0] dataIn;

  logic               busy, done, crcOk, crcErr;
  logic [MSG_W-1:0]   dataOut;
  logic [CRC14_W-1:0] syndrome;
  logic [15:0]        errCount;

  logic               busy2, done2, crcOk2, crcErr2;
  logic [MSG_W-1:0]   dataOut2;
  logic [CRC14_W-1:0] syndrome2;
  logic [1:0]         errCount2;

  int assertCount = 0;
  int failCount   = 0;
  int expErr      = 0;

  crc_check dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (dataIn),
    .busy     (busy),
    .done     (done),
    .data_out (dataOut),
    .crc_ok   (crcOk),
    .crc_err  (crcErr),
    .syndrome (syndrome),
    .err_count(errCount)
  );

  crc_check #(.CNT_W(2)) dutSat (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (dataIn),
    .busy     (busy2),
    .done     (done2),
    .data_out (dataOut2),
    .crc_ok   (crcOk2),
    .crc_err  (crcErr2),
    .syndrome (syndrome2),
    .err_count(errCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a codeword and lets edge E0 accept it.
  task automatic applyStimulus(input logic [CODEWORD_W-1:0] cw, input logic holdStart);
    start  = 1'b1;
    dataIn = cw;
    tick();
    if (!holdStart) start = 1'b0;
    checkOutput("busyAfterAccept", 32'(busy), 32'd1);
  endtask

  // Walks E1..E9: no done during SHIFT, done and idle right after E9.
  task automatic waitResult(input string tag);
    logic early;
    logic allBusy;
    early   = 1'b0;
    allBusy = 1'b1;
    repeat (8) begin
      tick();
      early   = early | done;
      allBusy = allBusy & busy;
    end
    checkOutput({tag, "/earlyDone"}, 32'(early), 32'd0);
    checkOutput({tag, "/busyDuringCheck"}, 32'(allBusy), 32'd1);
    tick();
    checkOutput({tag, "/done"}, 32'(done), 32'd1);
    checkOutput({tag, "/busyAfterCheck"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResult(input string tag, input logic okExp,
                             input logic [CRC14_W-1:0] syndExp, input logic [MSG_W-1:0] msgExp);
    int satExp;
    if (syndExp != '0 && expErr < 65535) expErr++;
    satExp = (expErr > 3) ? 3 : expErr;
    checkOutput({tag, "/crcOk"}, 32'(crcOk), 32'(okExp));
    checkOutput({tag, "/crcErr"}, 32'(crcErr), 32'(!okExp));
    checkOutput({tag, "/syndrome"}, 32'(syndrome), 32'(syndExp));
    checkOutput({tag, "/dataOut"}, 32'(dataOut), 32'(msgExp));
    checkOutput({tag, "/errCount"}, 32'(errCount), 32'(expErr));
    checkOutput({tag, "/errCountSat"}, 32'(errCount2), 32'(satExp));
    checkOutput({tag, "/satInstance"},
                32'({done2, busy2, dataOut2, crcOk2, crcErr2, syndrome2}),
                32'({1'b1, 1'b0, msgExp, okExp, !okExp, syndExp}));
  endtask

  logic [CODEWORD_W-1:0] b2bCw   [4] = '{22'h004599, 22'h004598, 22'h008B32, 22'h000599};
  logic                  b2bOk   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [CRC14_W-1:0]    b2bSynd [4] = '{14'h0000, 14'h0001, 14'h0000, 14'h0599};
  logic [MSG_W-1:0]      b2bMsg  [4] = '{8'h01, 8'h01, 8'h02, 8'h00};

  initial begin
    logic seenDone;
    rst    = 1'b1;
    start  = 1'b0;
    dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState",
                32'({busy, done, dataOut, crcOk, crcErr, syndrome}), 32'd0);
    checkOutput("resetErrCount", 32'(errCount), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic good and bad codewords");
    applyStimulus(22'h004599, 1'b0);
    waitResult("good01");
    checkResult("good01", 1'b1, 14'h0000, 8'h01);
    tick();
    checkOutput("good01/donePulse", 32'(done), 32'd0);
    checkOutput("good01/hold", 32'(dataOut), 32'h01);

    applyStimulus(22'h004598, 1'b0);
    waitResult("crcBit0");
    checkResult("crcBit0", 1'b0, 14'h0001, 8'h01);

    applyStimulus(22'h000599, 1'b0);
    waitResult("msgBit14");
    checkResult("msgBit14", 1'b0, 14'h0599, 8'h00);

    applyStimulus(22'h000000, 1'b0);
    waitResult("allZero");
    checkResult("allZero", 1'b1, 14'h0000, 8'h00);

    applyStimulus(22'h008B32, 1'b0);
    waitResult("good02");
    checkResult("good02", 1'b1, 14'h0000, 8'h02);

    $display("[TB] start and data changes while busy");
    applyStimulus(22'h004598, 1'b0);
    seenDone = 1'b0;
    repeat (2) begin
      tick();
      seenDone = seenDone | done;
    end
    start  = 1'b1;
    dataIn = 22'h000000;
    tick();
    seenDone = seenDone | done;
    start  = 1'b0;
    dataIn = 22'h008B32;
    repeat (5) begin
      tick();
      seenDone = seenDone | done;
    end
    checkOutput("busyStart/earlyDone", 32'(seenDone), 32'd0);
    tick();
    checkOutput("busyStart/done", 32'(done), 32'd1);
    checkResult("busyStart", 1'b0, 14'h0001, 8'h01);
    tick();
    checkOutput("busyStart/doneClear", 32'({done, busy}), 32'd0);
    tick();
    checkOutput("busyStart/noSecondCheck", 32'({done, busy}), 32'd0);

    $display("[TB] back-to-back checks with start held high");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(b2bCw[k], 1'b1);
      waitResult($sformatf("b2b%0d", k));
      checkResult($sformatf("b2b%0d", k), b2bOk[k], b2bSynd[k], b2bMsg[k]);
    end
    start = 1'b0;
    tick();
    checkOutput("b2b/endIdle", 32'({done, busy}), 32'd0);

    $display("[TB] reset in the middle of a check");
    applyStimulus(22'h004598, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checkOutput("midReset/outputs",
                32'({busy, done, dataOut, crcOk, crcErr, syndrome}), 32'd0);
    checkOutput("midReset/errCount", 32'(errCount), 32'd0);
    checkOutput("midReset/errCountSat", 32'(errCount2), 32'd0);
    expErr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seenDone = 1'b0;
    repeat (10) begin
      tick();
      seenDone = seenDone | done | busy;
    end
    checkOutput("midReset/noDone", 32'(seenDone), 32'd0);

    $display("[TB] error counter saturation");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(22'h004598, 1'b0);
      waitResult($sformatf("sat%0d", k));
      checkResult($sformatf("sat%0d", k), 1'b0, 14'h0001, 8'h01);
    end
    checkOutput("sat/finalWide", 32'(errCount), 32'd5);
    checkOutput("sat/finalNarrow", 32'(errCount2), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
